// File: rtl/ce_axis_tx_arb.sv
// ce_axis_tx_arb: packet-granular 2:1 round-robin merge of two AXI-S TX streams.
// Optional per-source packet counters when CE_TX_ARB_PKT_CNT_EN is defined.

module ce_axis_tx_arb #(
  parameter int DATA_WIDTH = 512,
  parameter int USER_WIDTH = 10,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  fim_clk,
  input  logic                  fim_rst_n,
  input  logic                  s0_tvalid,
  output logic                  s0_tready,
  input  logic [DATA_WIDTH-1:0] s0_tdata,
  input  logic [KEEP_WIDTH-1:0] s0_tkeep,
  input  logic [USER_WIDTH-1:0] s0_tuser,
  input  logic                  s0_tlast,
  input  logic                  s1_tvalid,
  output logic                  s1_tready,
  input  logic [DATA_WIDTH-1:0] s1_tdata,
  input  logic [KEEP_WIDTH-1:0] s1_tkeep,
  input  logic [USER_WIDTH-1:0] s1_tuser,
  input  logic                  s1_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic [KEEP_WIDTH-1:0] m_tkeep,
  output logic [USER_WIDTH-1:0] m_tuser,
  output logic                  m_tlast,
  output logic                  busy,
  output logic [31:0]           pkt_cnt0,
  output logic [31:0]           pkt_cnt1
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tlast;
  } beat_t;

  typedef enum logic [1:0] {
    IDLE,
    LOCK0,
    LOCK1
  } state_t;

  state_t state_q, state_d;
  logic   last_q, last_d;
  logic   space_q, space_d;
  logic   gnt0, gnt1;
  logic   acc0, acc1;
  logic   push, pop;
  beat_t  in_beat, main_q, skid_q;
  logic   main_v, skid_v;
  logic [1:0] occ, occ_d;

  // Grant is combinational in IDLE so a first beat moves the same cycle
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt0 = s0_tvalid && (!s1_tvalid || last_q);
        gnt1 = s1_tvalid && (!s0_tvalid || !last_q);
      end
      LOCK0: gnt0 = 1'b1;
      LOCK1: gnt1 = 1'b1;
      default: begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
      end
    endcase
  end

  assign s0_tready = gnt0 && space_q;
  assign s1_tready = gnt1 && space_q;
  assign acc0 = s0_tvalid && s0_tready;
  assign acc1 = s1_tvalid && s1_tready;
  assign push = acc0 || acc1;
  assign pop  = main_v && m_tready;

  assign in_beat = acc1 ? beat_t'{s1_tdata, s1_tkeep, s1_tuser, s1_tlast}
                        : beat_t'{s0_tdata, s0_tkeep, s0_tuser, s0_tlast};

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (acc0) begin
          last_d = 1'b0;
          if (!s0_tlast) state_d = LOCK0;
        end else if (acc1) begin
          last_d = 1'b1;
          if (!s1_tlast) state_d = LOCK1;
        end
      end
      LOCK0: if (acc0 && s0_tlast) state_d = IDLE;
      LOCK1: if (acc1 && s1_tlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge fim_clk or negedge fim_rst_n) begin
    if (!fim_rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Space looks one cycle ahead so ready never sees same-cycle m_tready
  assign occ   = {1'b0, main_v} + {1'b0, skid_v};
  assign occ_d = occ + {1'b0, push} - {1'b0, pop};
  assign space_d = !((occ_d == 2'd2) || ((occ_d == 2'd1) && !m_tready));

  always_ff @(posedge fim_clk or negedge fim_rst_n) begin
    if (!fim_rst_n) begin
      space_q <= 1'b0;
      main_v  <= 1'b0;
      skid_v  <= 1'b0;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      space_q <= space_d;
      if (!main_v || m_tready) begin
        if (skid_v) begin
          main_q <= skid_q;
          main_v <= 1'b1;
          skid_v <= push;
          if (push) skid_q <= in_beat;
        end else begin
          main_v <= push;
          if (push) main_q <= in_beat;
        end
      end else if (push) begin
        skid_q <= in_beat;
        skid_v <= 1'b1;
      end
    end
  end

  assign m_tvalid = main_v;
  assign m_tdata  = main_q.tdata;
  assign m_tkeep  = main_q.tkeep;
  assign m_tuser  = main_q.tuser;
  assign m_tlast  = main_q.tlast;
  assign busy     = (state_q != IDLE) || main_v || skid_v;

`ifdef CE_TX_ARB_PKT_CNT_EN
  logic [31:0] cnt0_q, cnt1_q;

  always_ff @(posedge fim_clk or negedge fim_rst_n) begin
    if (!fim_rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (acc0 && s0_tlast) cnt0_q <= cnt0_q + 32'd1;
      if (acc1 && s1_tlast) cnt1_q <= cnt1_q + 32'd1;
    end
  end

  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;
`else
  assign pkt_cnt0 = '0;
  assign pkt_cnt1 = '0;
`endif

endmodule

// File: tb/tb_ce_axis_tx_arb.sv
// tb_ce_axis_tx_arb: randomized + directed scoreboard bench for ce_axis_tx_arb.
// Packet counters are checked against the model when CE_TX_ARB_PKT_CNT_EN is set.

module tb_ce_axis_tx_arb;
  localparam int DW = 512;
  localparam int UW = 10;
  localparam int KW = DW / 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    s_tvalid;
  logic [1:0]    s_tready;
  logic [1:0]    s_tlast;
  logic [DW-1:0] s_tdata [2];
  logic [KW-1:0] s_tkeep [2];
  logic [UW-1:0] s_tuser [2];
  logic          m_tvalid;
  logic          m_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic [UW-1:0] m_tuser;
  logic          m_tlast;
  logic          busy;
  logic [31:0]   pkt_cnt0;
  logic [31:0]   pkt_cnt1;

  always #5 clk = ~clk;

  ce_axis_tx_arb dut (
    .fim_clk   (clk),
    .fim_rst_n (rst_n),
    .s0_tvalid (s_tvalid[0]),
    .s0_tready (s_tready[0]),
    .s0_tdata  (s_tdata[0]),
    .s0_tkeep  (s_tkeep[0]),
    .s0_tuser  (s_tuser[0]),
    .s0_tlast  (s_tlast[0]),
    .s1_tvalid (s_tvalid[1]),
    .s1_tready (s_tready[1]),
    .s1_tdata  (s_tdata[1]),
    .s1_tkeep  (s_tkeep[1]),
    .s1_tuser  (s_tuser[1]),
    .s1_tlast  (s_tlast[1]),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tdata   (m_tdata),
    .m_tkeep   (m_tkeep),
    .m_tuser   (m_tuser),
    .m_tlast   (m_tlast),
    .busy      (busy),
    .pkt_cnt0  (pkt_cnt0),
    .pkt_cnt1  (pkt_cnt1)
  );

  int    checks = 0;
  int    fails  = 0;
  int    cyc    = 0;
  int    mode   = 0;
  int    first_acc = -1;
  beat_t exp_q[$];

  // Reference model state: packet lock, round-robin history, per-source counts
  int          locked = -1;
  int          mlast  = 1;
  logic [31:0] mcnt [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Input-side model: records accepted beats, checks arbitration rules
  logic [1:0] acc;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      locked  = -1;
      mlast   = 1;
      mcnt[0] = '0;
      mcnt[1] = '0;
    end else begin
      acc = s_tvalid & s_tready;
      if (locked >= 0)
        chk("other_tready_in_lock", longint'(s_tready[1-locked]), 0);
      if (acc == 2'b11) begin
        checks++;
        fails++;
        $display("FAIL dual_accept actual=3 required=1");
      end
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin
          exp_q.push_back({s_tdata[i], s_tkeep[i], s_tuser[i], s_tlast[i]});
          if (first_acc < 0) first_acc = cyc;
          if (locked < 0) begin
            if (s_tvalid == 2'b11) chk("rr_order", i, 1 - mlast);
            mlast = i;
            if (!s_tlast[i]) locked = i;
          end else if (locked != i) begin
            checks++;
            fails++;
            $display("FAIL interleave actual=%0d required=%0d", i, locked);
          end else if (s_tlast[i]) begin
            locked = -1;
          end
          if (s_tlast[i]) mcnt[i] = mcnt[i] + 32'd1;
        end
      end
    end
  end

  // Output monitor: pops expected beats, checks stall stability
  logic  prev_stall = 1'b0;
  beat_t prev_b;
  beat_t cur;
  beat_t e;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      cur = {m_tdata, m_tkeep, m_tuser, m_tlast};
      if (prev_stall) begin
        checks++;
        if (!m_tvalid || cur !== prev_b) begin
          fails++;
          $display("FAIL stall_stable actual=%0h/%0b required=%0h/%0b",
                   cur.d[31:0], m_tvalid, prev_b.d[31:0], 1'b1);
        end
      end
      if (m_tvalid && m_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_beat actual=%0h required=none", cur.d[31:0]);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            fails++;
            $display("FAIL beat actual=%0h/%0h/%0b required=%0h/%0h/%0b",
                     cur.d[31:0], cur.u, cur.l, e.d[31:0], e.u, e.l);
          end
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_b     = cur;
    end
  end

  // m_tready generator; mode 2 also probes ready independence mid-cycle
  logic [1:0] r_snap;
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        1: m_tready = ($urandom_range(0, 99) < 70);
        2: begin
          m_tready = ~m_tready;
          #2;
          r_snap   = s_tready;
          m_tready = ~m_tready;
          #1;
          chk("tready_indep", longint'(s_tready), longint'(r_snap));
          m_tready = ~m_tready;
        end
        default: m_tready = 1'b1;
      endcase
    end
  end

  task automatic send_beat(input int src, input logic last);
    int t = 0;
    s_tvalid[src] = 1'b1;
    s_tdata[src]  = rnd_data();
    s_tkeep[src]  = {$urandom, $urandom};
    s_tuser[src]  = UW'($urandom);
    s_tlast[src]  = last;
    forever begin
      @(negedge clk);
      if (s_tready[src]) break;
      t++;
      if (t > 2000) begin
        checks++;
        fails++;
        $display("FAIL accept_timeout actual=src%0d_stuck required=accept", src);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input int src, input int len,
                          input int gap_at, input int gap_len);
    for (int b = 0; b < len; b++) begin
      if (b == gap_at) begin
        s_tvalid[src] = 1'b0;
        repeat (gap_len) @(posedge clk);
        #1;
      end
      send_beat(src, b == len - 1);
    end
    s_tvalid[src] = 1'b0;
  endtask

  task automatic drive(input int src, input int npkt, input int gap_pct);
    int len;
    for (int p = 0; p < npkt; p++) begin
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 99) < gap_pct) begin
          s_tvalid[src] = 1'b0;
          @(posedge clk);
          #1;
        end
        send_beat(src, b == len - 1);
      end
    end
    s_tvalid[src] = 1'b0;
  endtask

  task automatic measure(input int n, output int first_cyc, output int nvalid);
    int t = 0;
    nvalid    = 0;
    first_cyc = -1;
    forever begin
      @(negedge clk);
      if (m_tvalid) break;
      t++;
      if (t > 500) begin
        checks++;
        fails++;
        $display("FAIL out_timeout actual=no_valid required=valid");
        return;
      end
    end
    first_cyc = cyc;
    nvalid    = 1;
    repeat (n - 1) begin
      @(negedge clk);
      if (m_tvalid) nvalid++;
    end
  endtask

  task automatic check_cnt(input string tag);
`ifdef CE_TX_ARB_PKT_CNT_EN
    chk({tag, "_cnt0"}, longint'(pkt_cnt0), longint'(mcnt[0]));
    chk({tag, "_cnt1"}, longint'(pkt_cnt1), longint'(mcnt[1]));
`else
    chk({tag, "_cnt0"}, longint'(pkt_cnt0), 0);
    chk({tag, "_cnt1"}, longint'(pkt_cnt1), 0);
`endif
  endtask

  task automatic settle(input string tag);
    repeat (6) @(posedge clk);
    #1;
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_drain"}, exp_q.size(), 0);
    check_cnt(tag);
  endtask

  int fc, nv;

  initial begin
    rst_n    = 1'b0;
    s_tvalid = '0;
    s_tlast  = '0;
    for (int i = 0; i < 2; i++) begin
      s_tdata[i] = '0;
      s_tkeep[i] = '0;
      s_tuser[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_tvalid", longint'(m_tvalid), 0);
    chk("rst_m_tdata", longint'(m_tdata[63:0]), 0);
    chk("rst_m_tlast", longint'(m_tlast), 0);
    chk("rst_busy", longint'(busy), 0);
    check_cnt("rst");

    rst_n    = 1'b1;
    s_tvalid = 2'b11;
    @(negedge clk);
    chk("rst_first_tready", longint'(s_tready), 0);
    @(posedge clk);
    #1;
    s_tvalid = 2'b00;

    // single 3-beat packet: t+1 latency, no bubbles
    first_acc = -1;
    fork
      send_pkt(0, 3, -1, 0);
      measure(3, fc, nv);
    join
    chk("t1_latency", fc, first_acc + 1);
    chk("t1_valid_beats", nv, 3);
    settle("t1");

    // both sources back-to-back 2-beat packets: full duty cycle
    fork
      repeat (4) send_pkt(0, 2, -1, 0);
      repeat (4) send_pkt(1, 2, -1, 0);
      measure(16, fc, nv);
    join
    chk("t2_duty", nv, 16);
    settle("t2");

    // s0 mid-packet gap holds lock; s1 waits
    fork
      send_pkt(0, 4, 2, 2);
      begin
        repeat (2) @(posedge clk);
        #1;
        send_pkt(1, 2, -1, 0);
      end
      measure(8, fc, nv);
    join
    chk("t3_valid_with_bubbles", nv, 6);
    settle("t3");

    // alternating backpressure on an 8-beat packet
    mode = 2;
    send_pkt(0, 8, -1, 0);
    repeat (6) @(posedge clk);
    mode = 0;
    settle("t4");

    // reset after beat 2 of a 4-beat packet
    send_beat(0, 1'b0);
    send_beat(0, 1'b0);
    rst_n    = 1'b0;
    s_tvalid = 2'b00;
    #1;
    chk("t5_m_tvalid", longint'(m_tvalid), 0);
    chk("t5_busy", longint'(busy), 0);
    chk("t5_cnt0", longint'(pkt_cnt0), 0);
    chk("t5_cnt1", longint'(pkt_cnt1), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    s_tvalid = 2'b11;
    @(negedge clk);
    chk("t5_first_tready", longint'(s_tready), 0);
    @(posedge clk);
    #1;
    fork
      send_pkt(0, 1, -1, 0);
      send_pkt(1, 1, -1, 0);
    join
    settle("t5");

`ifdef CE_TX_ARB_PKT_CNT_EN
    force dut.cnt0_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt0_q;
    mcnt[0] = 32'hFFFF_FFFF;
    send_pkt(0, 2, -1, 0);
    settle("t6_wrap");
    chk("t6_cnt0_zero", longint'(pkt_cnt0), 0);
`endif

    // randomized traffic with random backpressure
    mode = 1;
    fork
      drive(0, 30, 30);
      drive(1, 30, 30);
    join
    repeat (20) @(posedge clk);
    mode = 0;
    settle("t7");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
